// File: rtl/c_buffer_drain_pkg.sv
// Shared constants, FSM encoding and lane helper for the C buffer drain.
package c_buffer_drain_pkg;

  localparam int unsigned ARRAY_SIZE = 4;
  localparam int unsigned IDX_W      = 12;
  localparam int unsigned CNT_W      = 16;

  localparam int signed INT8_MIN = -128;
  localparam int signed INT8_MAX = 127;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StLoad  = 3'd2;
  localparam logic [2:0] StReq   = 3'd3;
  localparam logic [2:0] StEmit  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  // Lane 0 lives in the most significant 32 bits of a C word.
  function automatic logic [31:0] lane_slice(input logic [127:0] word, input logic [1:0] idx);
    return word[32 * (3 - int'(idx)) +: 32];
  endfunction

endpackage

// File: rtl/c_buffer_drain_if.sv
// 32-bit valid/ready result stream from the drain to the host response path.
interface c_buffer_drain_if;

  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/c_buffer_drain_requant_lane.sv
// Combinational int32 -> int8 requantization of one lane: scale, round, offset, saturate.
module c_buffer_drain_requant_lane
  import c_buffer_drain_pkg::*;
(
  input  logic [31:0] x_i,
  input  logic [31:0] mult_i,
  input  logic [4:0]  shift_i,
  input  logic [31:0] offset_i,
  output logic [7:0]  y_o
);

  logic signed [63:0] prod;
  logic signed [63:0] rnd;
  logic signed [63:0] rounded;
  logic signed [63:0] biased;

  // Round-half-up arithmetic shift, then offset and clamp to the int8 range.
  always_comb begin
    prod    = $signed({{32{x_i[31]}}, x_i}) * $signed({{32{mult_i[31]}}, mult_i});
    rnd     = '0;
    rounded = prod;
    if (shift_i != 5'd0) begin
      rnd     = 64'sd1 <<< (shift_i - 5'd1);
      rounded = (prod + rnd) >>> shift_i;
    end
    biased = rounded + $signed({{32{offset_i[31]}}, offset_i});
    if (biased < 64'(INT8_MIN)) begin
      y_o = 8'h80;
    end else if (biased > 64'(INT8_MAX)) begin
      y_o = 8'h7f;
    end else begin
      y_o = biased[7:0];
    end
  end

endmodule

// File: rtl/c_buffer_drain.sv
// Drains the 4-lane C result buffer onto a 32-bit stream, raw or requantized to int8.
module c_buffer_drain
  import c_buffer_drain_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         M,
  input  logic [7:0]         N,
  input  logic               requant_en,
  input  logic [31:0]        mult,
  input  logic [4:0]         shift,
  input  logic [31:0]        out_offset,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   C_rd_idx,
  input  logic [127:0]       C_data_o,
  c_buffer_drain_if.master   out_if
);

  localparam logic [1:0] LastLane = 2'(ARRAY_SIZE - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             requant_q, requant_d;
  logic [31:0]      mult_q, mult_d;
  logic [4:0]       shift_q, shift_d;
  logic [31:0]      offset_q, offset_d;
  logic [127:0]     hold_q, hold_d;
  logic [31:0]      packed_q, packed_d;
  logic [1:0]       lane_q, lane_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] start_words;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       lane_q8 [ARRAY_SIZE];
  logic             emit;

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : gen_lane
    c_buffer_drain_requant_lane u_requant_lane (
      .x_i      (lane_slice(hold_q, 2'(g))),
      .mult_i   (mult_q),
      .shift_i  (shift_q),
      .offset_i (offset_q),
      .y_o      (lane_q8[g])
    );
  end

  // Word count and counter increment; N rounds up to whole 4-lane words.
  always_comb begin
    start_words = CNT_W'(M) * ((CNT_W'(N) + CNT_W'(3)) >> 2);
    cnt_inc     = cnt_q + CNT_W'(1);
  end

  // Drain sequencer: fetch a word, capture it, optionally requantize, then emit its beats.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    words_d   = words_q;
    requant_d = requant_q;
    mult_d    = mult_q;
    shift_d   = shift_q;
    offset_d  = offset_q;
    hold_d    = hold_q;
    packed_d  = packed_q;
    lane_d    = lane_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          words_d   = start_words;
          requant_d = requant_en;
          mult_d    = mult;
          shift_d   = shift;
          offset_d  = out_offset;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = (start_words == '0) ? StDone : StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        hold_d  = C_data_o;
        lane_d  = '0;
        state_d = requant_q ? StReq : StEmit;
      end
      StReq: begin
        packed_d = {lane_q8[0], lane_q8[1], lane_q8[2], lane_q8[3]};
        state_d  = StEmit;
      end
      StEmit: begin
        if (out_if.out_ready) begin
          if (!requant_q && lane_q != LastLane) begin
            lane_d = lane_q + 2'd1;
          end else begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == words_q) ? StDone : StFetch;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any drain in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      words_q   <= '0;
      requant_q <= 1'b0;
      mult_q    <= '0;
      shift_q   <= '0;
      offset_q  <= '0;
      hold_q    <= '0;
      packed_q  <= '0;
      lane_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      words_q   <= words_d;
      requant_q <= requant_d;
      mult_q    <= mult_d;
      shift_q   <= shift_d;
      offset_q  <= offset_d;
      hold_q    <= hold_d;
      packed_q  <= packed_d;
      lane_q    <= lane_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Stream outputs come only from registers, so they hold steady under backpressure.
  always_comb begin
    emit             = (state_q == StEmit);
    out_if.out_valid = emit;
    out_if.out_data  = '0;
    out_if.out_last  = 1'b0;
    if (emit) begin
      out_if.out_data = requant_q ? packed_q : lane_slice(hold_q, lane_q);
      out_if.out_last = (cnt_q == words_q - CNT_W'(1)) && (requant_q || lane_q == LastLane);
    end
    busy     = busy_q;
    done     = done_q;
    C_rd_idx = cnt_q[IDX_W-1:0];
  end

endmodule

// File: tb/tb_c_buffer_drain.sv
// Directed and randomized drains of c_buffer_drain checked against a lane-level reference model.
module tb_c_buffer_drain;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   M;
  logic [7:0]   N;
  logic         requant_en;
  logic [31:0]  mult;
  logic [4:0]   shift;
  logic [31:0]  out_offset;
  logic         busy;
  logic         done;
  logic [11:0]  C_rd_idx;
  logic [127:0] c_data;

  c_buffer_drain_if stream_if ();

  c_buffer_drain u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .M          (M),
    .N          (N),
    .requant_en (requant_en),
    .mult       (mult),
    .shift      (shift),
    .out_offset (out_offset),
    .busy       (busy),
    .done       (done),
    .C_rd_idx   (C_rd_idx),
    .C_data_o   (c_data),
    .out_if     (stream_if.master)
  );

  always #5 clk = ~clk;

  // C buffer memory: one-cycle read latency.
  logic [127:0] mem [0:4095];
  always @(posedge clk) c_data <= mem[C_rd_idx];

  int           lv [0:63][0:3];
  int           checks = 0;
  int           failures = 0;
  int           ready_mode = 0;
  logic [31:0]  beats [$];
  logic         lasts [$];
  logic [11:0]  idx_seen [$];
  int           done_cnt = 0;
  int           valid_seen = 0;
  logic [31:0]  exp_data [$];
  logic         exp_last [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] model_q8(input int x, input int m, input int sh, input int off);
    longint p;
    longint r;
    longint y;
    p = longint'(x) * longint'(m);
    if (sh == 0) r = p;
    else r = (p + (longint'(1) << (sh - 1))) >>> sh;
    y = r + longint'(off);
    if (y < -128) y = -128;
    else if (y > 127) y = 127;
    return y[7:0];
  endfunction

  task automatic set_word(input int k, input int a, input int b, input int c, input int d);
    lv[k][0] = a; lv[k][1] = b; lv[k][2] = c; lv[k][3] = d;
    mem[k] = {a, b, c, d};
  endtask

  task automatic fill(input int w, input bit rnd);
    for (int k = 0; k < w; k++) begin
      if (rnd) set_word(k, $urandom, $urandom, $urandom, $urandom);
      else set_word(k, 4 * k, 4 * k + 1, 4 * k + 2, 4 * k + 3);
    end
  endtask

  // out_ready: 0 = always high, 1 = repeating 1,0,0,1, 2 = random.
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    stream_if.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) begin
        stream_if.out_ready = pat[ph % 4];
        ph++;
      end else if (ready_mode == 2) stream_if.out_ready = 1'($urandom_range(0, 1));
      else stream_if.out_ready = 1'b1;
    end
  end

  // Observer: logs beats, done pulses, read indices, and checks stall stability.
  initial begin
    logic        stall_prev;
    logic [31:0] prev_data;
    logic        prev_last;
    stall_prev = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) stall_prev = 1'b0;
      else begin
        if (stall_prev) begin
          checks++;
          assert (stream_if.out_valid === 1'b1 && stream_if.out_data === prev_data &&
                  stream_if.out_last === prev_last) else begin
            failures++;
            $error("FAIL stall_stable observed=%0b/%0h/%0b expected=1/%0h/%0b",
                   stream_if.out_valid, stream_if.out_data, stream_if.out_last,
                   prev_data, prev_last);
          end
        end
        stall_prev = stream_if.out_valid && !stream_if.out_ready;
        prev_data = stream_if.out_data;
        prev_last = stream_if.out_last;
        if (stream_if.out_valid && stream_if.out_ready) begin
          beats.push_back(stream_if.out_data);
          lasts.push_back(stream_if.out_last);
        end
        if (stream_if.out_valid) valid_seen++;
        if (done) done_cnt++;
        if (busy && (idx_seen.size() == 0 || idx_seen[$] != C_rd_idx)) idx_seen.push_back(C_rd_idx);
      end
    end
  end

  task automatic run_drain(input int m, input int n, input bit req, input int mlt, input int sh,
                           input int off, input int rmode, input int poke_at,
                           input int rst_after, input bit check_idx);
    int w;
    bit fin;
    int nb;
    w = m * ((n + 3) / 4);
    exp_data.delete();
    exp_last.delete();
    for (int k = 0; k < w; k++) begin
      if (req) begin
        exp_data.push_back({model_q8(lv[k][0], mlt, sh, off), model_q8(lv[k][1], mlt, sh, off),
                            model_q8(lv[k][2], mlt, sh, off), model_q8(lv[k][3], mlt, sh, off)});
        exp_last.push_back(k == w - 1);
      end else begin
        for (int j = 0; j < 4; j++) begin
          exp_data.push_back(lv[k][j]);
          exp_last.push_back(k == w - 1 && j == 3);
        end
      end
    end
    ready_mode = rmode;
    beats.delete();
    lasts.delete();
    idx_seen.delete();
    done_cnt = 0;
    valid_seen = 0;
    @(posedge clk); #1;
    M = 8'(m); N = 8'(n); requant_en = req; mult = mlt; shift = 5'(sh); out_offset = off;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    M = 8'($urandom); N = 8'($urandom); requant_en = 1'($urandom);
    mult = $urandom; shift = 5'($urandom); out_offset = $urandom;
    fin = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(posedge clk); #1;
      start = (c == poke_at);
      if (reset) begin
        reset = 1'b0;
        check("reset_valid", stream_if.out_valid, 0);
        check("reset_busy", busy, 0);
        nb = beats.size();
        repeat (12) @(posedge clk);
        #1;
        check("reset_no_beats", beats.size(), nb);
        check("reset_no_done", done_cnt, 0);
        ready_mode = 0;
        return;
      end else if (rst_after >= 0 && beats.size() >= rst_after) reset = 1'b1;
      else if (done_cnt != 0) fin = 1'b1;
    end
    start = 1'b0;
    check("drain_finished", fin, 1);
    repeat (3) @(posedge clk);
    #1;
    check("beat_count", beats.size(), exp_data.size());
    for (int k = 0; k < exp_data.size() && k < beats.size(); k++) begin
      check($sformatf("beat_data[%0d]", k), beats[k], exp_data[k]);
      check($sformatf("beat_last[%0d]", k), lasts[k], exp_last[k]);
    end
    check("done_pulses", done_cnt, 1);
    check("busy_after", busy, 0);
    if (check_idx) begin
      for (int k = 0; k < w; k++) begin
        check($sformatf("rd_idx[%0d]", k), (k < idx_seen.size()) ? idx_seen[k] : 12'hxxx, k);
      end
    end
    ready_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b;
    reset = 1'b1; start = 1'b0; M = '0; N = '0; requant_en = 1'b0;
    mult = '0; shift = '0; out_offset = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_idx", C_rd_idx, 0);
    check("rst_out_valid", stream_if.out_valid, 0);
    check("rst_out_data", stream_if.out_data, 0);
    check("rst_out_last", stream_if.out_last, 0);

    // Raw 4x4: beats 0..15.
    fill(4, 1'b0);
    run_drain(4, 4, 1'b0, 0, 0, 0, 0, -1, -1, 1'b1);
    b = (beats.size() > 15) ? beats[15] : 'x;
    check("raw_beat15", b, 15);

    // N=5, M=3: six words, indices 0..5.
    fill(6, 1'b0);
    run_drain(3, 5, 1'b0, 0, 0, 0, 0, -1, -1, 1'b1);

    // Backpressure 1,0,0,1 on the same 4x4 data.
    fill(4, 1'b0);
    run_drain(4, 4, 1'b0, 0, 0, 0, 1, -1, -1, 1'b1);

    // Requant identity with saturation on both sides.
    set_word(0, 5, -3, 300, -300);
    run_drain(1, 4, 1'b1, 1, 0, 0, 0, -1, -1, 1'b0);
    b = (beats.size() > 0) ? beats[0] : 'x;
    check("rq_identity", b, 32'h05FD7F80);

    // Requant with rounding shift and negative offset: 10*3=30 -> 8 -> 7.
    set_word(0, 10, 0, -1000, 7);
    run_drain(1, 1, 1'b1, 3, 2, -1, 0, -1, -1, 1'b0);
    b = (beats.size() > 0) ? beats[0] : 'x;
    check("rq_shift_byte0", b[31:24], 8'h07);

    // M=0: done two cycles after start, no output.
    valid_seen = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    M = 8'd0; N = 8'd4; requant_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("m0_done_early", done, 0);
    check("m0_busy", busy, 1);
    @(posedge clk); #1;
    check("m0_done", done, 1);
    check("m0_busy_after", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("m0_no_valid", valid_seen, 0);
    check("m0_done_pulses", done_cnt, 1);

    // start pulsed mid-drain is ignored.
    fill(4, 1'b0);
    run_drain(4, 4, 1'b0, 0, 0, 0, 0, 5, -1, 1'b1);

    // Reset at beat 5 aborts; a fresh drain restarts from index 0.
    fill(4, 1'b1);
    run_drain(4, 4, 1'b0, 0, 0, 0, 0, -1, 5, 1'b0);
    run_drain(4, 4, 1'b0, 0, 0, 0, 0, -1, -1, 1'b1);

    // Randomized drains under random backpressure.
    for (int t = 0; t < 6; t++) begin
      int m;
      int n;
      int mlt;
      m = $urandom_range(1, 5);
      n = $urandom_range(1, 9);
      mlt = ($urandom_range(0, 1) != 0) ? int'($urandom) : $urandom_range(0, 600) - 300;
      fill(m * ((n + 3) / 4), 1'b1);
      run_drain(m, n, 1'($urandom_range(0, 1)), mlt, $urandom_range(0, 31),
                $urandom_range(0, 400) - 200, 2, -1, -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
